// File: rtl/req_encoder_8to3_pkg.sv
// enc_pkg: shared constants, FSM states and code-to-mask helper for req_encoder_8to3
package enc_pkg;
  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;
  typedef enum logic {IDLE, HOLD} state_e;
  function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] c);
    return N_REQ'(1) << c;
  endfunction
endpackage

// File: rtl/req_encoder_8to3_if.sv
// req_encoder_8to3_if: request inputs and valid/ready code output of the encoder
interface req_encoder_8to3_if;
  import enc_pkg::*;
  logic [N_REQ-1:0]  req_i;
  logic [CODE_W-1:0] code_o;
  logic              valid_o;
  logic              ready_i;
  logic [N_REQ-1:0]  pending_o;
  logic              busy_o;
  modport master (output req_i, ready_i, input code_o, valid_o, pending_o, busy_o);
  modport slave  (input req_i, ready_i, output code_o, valid_o, pending_o, busy_o);
endinterface

// File: rtl/req_encoder_8to3_pri_enc8.sv
// pri_enc8: combinational 8-to-3 priority encoder searching upward from base_i+1 with wrap
module pri_enc8 import enc_pkg::*; (
  input  logic [N_REQ-1:0]  vec_i,
  input  logic [CODE_W-1:0] base_i,
  output logic [CODE_W-1:0] code_o,
  output logic              any_o
);
  // Scan farthest-first so the set bit nearest base_i+1 is written last and wins
  always_comb begin
    code_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (vec_i[base_i + CODE_W'(i + 1)]) code_o = base_i + CODE_W'(i + 1);
  end
  assign any_o = |vec_i;
endmodule

// File: rtl/req_encoder_8to3.sv
// req_encoder_8to3: pending-request collector emitting priority-ordered codes; ENC_RR_EN selects round-robin priority
module req_encoder_8to3 import enc_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  req_encoder_8to3_if.slave bus
);
  state_e            state_q;
  logic [CODE_W-1:0] code_q, sel, base;
  logic [N_REQ-1:0]  p_q, p_d;
  logic              any, load;
`ifdef ENC_RR_EN
  logic [CODE_W-1:0] rr_q;
  // Rotation pointer follows the most recently loaded index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_q <= CODE_W'(N_REQ - 1);
    else if (load) rr_q <= sel;
  assign base = rr_q;
`else
  assign base = CODE_W'(N_REQ - 1);
`endif
  pri_enc8 u_enc (.vec_i(p_q), .base_i(base), .code_o(sel), .any_o(any));
  assign load = (state_q == IDLE || bus.ready_i) && any;
  assign p_d  = (p_q & ~(load ? onehot(sel) : '0)) | bus.req_i;
  // Pending register plus output-stage FSM: load a new code when free, fall idle after the last accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      p_q     <= '0;
    end else begin
      p_q <= p_d;
      if (load) begin
        code_q  <= sel;
        state_q <= HOLD;
      end else if (bus.ready_i) state_q <= IDLE;
    end
  assign bus.code_o    = code_q;
  assign bus.valid_o   = (state_q == HOLD);
  assign bus.pending_o = p_q;
  assign bus.busy_o    = (state_q == HOLD) | (|p_q);
endmodule
